bsg_fifo_ptr_ctrl: RTL and testbench
====================================

# bsg_fifo_ptr_ctrl

Control block for a circular-buffer FIFO. It sequences one write and one read circular pointer over an external `els_p`-entry storage array. It derives full, empty, almost-full and occupancy from the pointer state and a last-operation flag. It sits between a valid/ready producer, a valid/yumi consumer and a 1R1W memory; it holds no data.

## Interface
- `els_p`, 4: number of storage entries, ≥2; need not be a power of two.
- `almost_full_thresh_p`, `els_p-1`: occupancy at or above which `almost_full_o` is high; range 1..`els_p`.
- `ptr_width_lp` (derived): `$clog2(els_p)`.
- `count_width_lp` (derived): `$clog2(els_p+1)`.

Ports:
- `clk` input 1: single clock; all state is on its rising edge.
- `reset_i` input 1: asynchronous, active-high reset. Assertion clears state immediately. Deassertion is synchronized externally.
- `v_i` input 1: producer has an element.
- `ready_o` output 1: an entry is free; enqueue occurs when `v_i & ready_o`.
- `v_o` output 1: FIFO is non-empty.
- `yumi_i` input 1: consumer takes the head entry; legal only when `v_o`=1.
- `w_en_o` output 1: memory write strobe, equal to `v_i & ready_o`.
- `w_addr_o` output `ptr_width_lp`: write address, the registered write pointer.
- `r_addr_o` output `ptr_width_lp`: current head address, the registered read pointer.
- `r_addr_n_o` output `ptr_width_lp`: next-cycle read pointer, for synchronous-read memories.
- `full_o` output 1: all entries occupied.
- `empty_o` output 1: no entries occupied.
- `almost_full_o` output 1: `count_o >= almost_full_thresh_p`.
- `count_o` output `count_width_lp`: occupancy, 0..`els_p`.

## Operation
- **State:** `wptr_r`, `rptr_r` (circular, 0..`els_p`-1), `enq_last_r` (1 = last pointer-changing event was an enqueue-only), `count_r`.
- **Pointer advance:**
  - `enq = v_i & ready_o`.
  - `deq = yumi_i`.
  - `wptr` advances by `enq`; `rptr` advances by `deq`.
  - Each pointer wraps from `els_p`-1 to 0; there is no power-of-two assumption.
- **Full/empty:**
  - `empty_o = (wptr_r==rptr_r) & ~enq_last_r`.
  - `full_o = (wptr_r==rptr_r) & enq_last_r`.
  - `ready_o = ~full_o`.
  - `v_o = ~empty_o`.
- **`enq_last_r` update:**
  - Set on enq & ~deq.
  - Cleared on deq & ~enq.
  - Unchanged when both or neither occur.
- **`count_r` update:** +1 on enq-only, −1 on deq-only, unchanged otherwise. Must always equal `(wptr_r−rptr_r) mod els_p`, or `els_p` when full (checked by assertion).
- **No bypass:**
  - `ready_o` does not depend on `yumi_i`: a full FIFO refuses enqueue even in a cycle with dequeue.
  - `v_o` does not depend on `v_i`: an empty FIFO never presents same-cycle input.
- **Simultaneous enq+deq (0 < count < `els_p`):** both pointers advance; count and flags are unchanged.
- **Illegal input:** `yumi_i` while `empty_o` is a protocol error. Simulation assertion fires; RTL ignores it (deq gated by `v_o` internally).

## Timing
- **Reset values:**
  - Pointers = 0, `count_o`=0, `enq_last_r`=0.
  - Outputs: `empty_o`=1, `full_o`=0, `ready_o`=1, `v_o`=0, `almost_full_o`=0, `w_en_o`=`v_i`.
  - All take effect asynchronously on `reset_i` rise, including mid-operation; contents are abandoned.
- **Latency:** an enqueue at edge N gives `v_o`=1 after edge N (one-cycle fall-through latency). `r_addr_n_o` equals `r_addr_o` one cycle early.
- **Combinational paths:**
  - `ready_o`, `v_o`, `full_o`, `empty_o`, `almost_full_o`, `count_o`, `w_addr_o` and `r_addr_o` are functions of registers only.
  - `w_en_o` depends combinationally on `v_i`; `r_addr_n_o` depends on `yumi_i`.

## Structure
- **Sub-module `bsg_circ_ptr_ar`:**
  - Parameters `slots_p`, `max_add_p`=1.
  - Ports `clk`, `reset_i` (async), `add_i`, `o`, `n_o`.
  - Wraps modulo `slots_p`; instantiated twice.
- **Shared package `bsg_fifo_pkg`:**
  - Width helper functions for pointer and count widths.
  - Enum `fifo_op_e {NONE, ENQ, DEQ, BOTH}`, used for the flag/count update decode and for coverage.

## Test plan
- **Reset mid-stream:** `els_p`=5, enqueue 3 then assert `reset_i` between edges → `count_o`=0, `empty_o`=1 and `r_addr_o`=0 immediately, before the next edge.
- **Fill:** `els_p`=5, enqueue 5 with no dequeue → `full_o`=1, `ready_o`=0, `count_o`=5, `w_addr_o`=0. A 6th `v_i` gives `w_en_o`=0.
- **Non-power-of-two wrap:** `els_p`=5, 7 enq/deq pairs interleaved singly → `w_addr_o` sequence 0,1,2,3,4,0,1,2. Count alternates 1/0 and `empty_o` toggles accordingly.
- **Simultaneous enq+deq:** count=2, `v_i`=`yumi_i`=1 for 4 cycles → count stays 2 and both pointers advance by 4 mod 5.
- **No bypass:** full, `v_i`=`yumi_i`=1 → dequeue only; next cycle count=4, `ready_o`=1.
- **Almost-full:** `almost_full_thresh_p`=3 → `almost_full_o` rises at count 3 and falls on the dequeue to 2.

Source files
------------

// File: rtl/bsg_fifo_pkg.sv
// Shared types and width helpers for the FIFO pointer controller and its sub-blocks.
package bsg_fifo_pkg;

    typedef enum logic [1:0] {NONE, ENQ, DEQ, BOTH} fifo_op_e;

    function automatic int unsigned ptr_width(input int unsigned els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned els);
        return $clog2(els + 1);
    endfunction

    function automatic fifo_op_e decode_op(input logic enq, input logic deq);
        case ({enq, deq})
            2'b10:   return ENQ;
            2'b01:   return DEQ;
            2'b11:   return BOTH;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/bsg_fifo_ptr_ctrl_if.sv
// Producer/consumer handshake plus memory-side address bundle of the FIFO controller.
interface bsg_fifo_ptr_ctrl_if #(
    parameter int unsigned ptr_width_p   = 2,
    parameter int unsigned count_width_p = 3
);
    logic                     v_i;
    logic                     ready_o;
    logic                     v_o;
    logic                     yumi_i;
    logic                     w_en_o;
    logic [ptr_width_p-1:0]   w_addr_o;
    logic [ptr_width_p-1:0]   r_addr_o;
    logic [ptr_width_p-1:0]   r_addr_n_o;
    logic                     full_o;
    logic                     empty_o;
    logic                     almost_full_o;
    logic [count_width_p-1:0] count_o;

    modport slave (
        input  v_i, yumi_i,
        output ready_o, v_o, w_en_o, w_addr_o, r_addr_o, r_addr_n_o,
               full_o, empty_o, almost_full_o, count_o
    );

    modport master (
        output v_i, yumi_i,
        input  ready_o, v_o, w_en_o, w_addr_o, r_addr_o, r_addr_n_o,
               full_o, empty_o, almost_full_o, count_o
    );
endinterface

// File: rtl/bsg_circ_ptr_ar.sv
// Circular pointer modulo slots_p with asynchronous reset; n_o is the next-cycle value.
module bsg_circ_ptr_ar
    import bsg_fifo_pkg::*;
#(
    parameter int unsigned slots_p   = 4,
    parameter int unsigned max_add_p = 1,
    localparam int unsigned ptr_w_lp = ptr_width(slots_p),
    localparam int unsigned add_w_lp = $clog2(max_add_p + 1)
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic [add_w_lp-1:0] add_i,
    output logic [ptr_w_lp-1:0] o,
    output logic [ptr_w_lp-1:0] n_o
);

    localparam logic [ptr_w_lp:0] SlotsL = (ptr_w_lp + 1)'(slots_p);

    logic [ptr_w_lp-1:0] ptr_q, ptr_d;
    logic [ptr_w_lp:0]   sum;

    // One extra bit holds ptr+add without overflow since add <= slots_p.
    always_comb begin
        sum   = (ptr_w_lp + 1)'(ptr_q) + (ptr_w_lp + 1)'(add_i);
        ptr_d = (sum >= SlotsL) ? ptr_w_lp'(sum - SlotsL) : ptr_w_lp'(sum);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign o   = ptr_q;
    assign n_o = ptr_d;

endmodule

// File: rtl/bsg_fifo_ptr_ctrl.sv
// Circular-buffer FIFO control: write/read pointers, full/empty/almost-full and occupancy.
module bsg_fifo_ptr_ctrl
    import bsg_fifo_pkg::*;
#(
    parameter int unsigned els_p                = 4,
    parameter int unsigned almost_full_thresh_p = els_p - 1
) (
    input logic               clk,
    input logic               reset_i,
    bsg_fifo_ptr_ctrl_if.slave fifo_io
);

    localparam int unsigned ptr_width_lp   = ptr_width(els_p);
    localparam int unsigned count_width_lp = count_width(els_p);

    logic [ptr_width_lp-1:0]   wptr, wptr_n, rptr, rptr_n;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq_last_q, enq_last_d;
    logic                      ptr_eq, full, empty, enq, deq;
    fifo_op_e                  op;

    assign ptr_eq = (wptr == rptr);
    assign full   = ptr_eq & enq_last_q;
    assign empty  = ptr_eq & ~enq_last_q;

    // Neither side bypasses: ready ignores yumi, and deq is gated so a stray yumi is dropped.
    assign enq = fifo_io.v_i & ~full;
    assign deq = fifo_io.yumi_i & ~empty;
    assign op  = decode_op(enq, deq);

    bsg_circ_ptr_ar #(.slots_p(els_p), .max_add_p(1)) u_wptr (
        .clk     (clk),
        .reset_i (reset_i),
        .add_i   (enq),
        .o       (wptr),
        .n_o     (wptr_n)
    );

    bsg_circ_ptr_ar #(.slots_p(els_p), .max_add_p(1)) u_rptr (
        .clk     (clk),
        .reset_i (reset_i),
        .add_i   (deq),
        .o       (rptr),
        .n_o     (rptr_n)
    );

    always_comb begin
        enq_last_d = enq_last_q;
        count_d    = count_q;
        case (op)
            ENQ: begin
                enq_last_d = 1'b1;
                count_d    = count_q + count_width_lp'(1);
            end
            DEQ: begin
                enq_last_d = 1'b0;
                count_d    = count_q - count_width_lp'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            enq_last_q <= 1'b0;
            count_q    <= '0;
        end else begin
            enq_last_q <= enq_last_d;
            count_q    <= count_d;
        end
    end

    assign fifo_io.ready_o       = ~full;
    assign fifo_io.v_o           = ~empty;
    assign fifo_io.full_o        = full;
    assign fifo_io.empty_o       = empty;
    assign fifo_io.w_en_o        = enq;
    assign fifo_io.w_addr_o      = wptr;
    assign fifo_io.r_addr_o      = rptr;
    assign fifo_io.r_addr_n_o    = rptr_n;
    assign fifo_io.count_o       = count_q;
    assign fifo_io.almost_full_o = (count_q >= count_width_lp'(almost_full_thresh_p));

    a_yumi_when_empty: assert property (@(posedge clk) disable iff (reset_i)
        !(fifo_io.yumi_i && empty));

    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (reset_i)
        int'(count_q) == (full ? int'(els_p)
                               : (int'(wptr) + int'(els_p) - int'(rptr)) % int'(els_p)));

    a_wptr_in_range: assert property (@(posedge clk) disable iff (reset_i)
        int'(wptr_n) < int'(els_p));

endmodule

// File: tb/tb_bsg_fifo_ptr_ctrl.sv
// Directed bench for bsg_fifo_ptr_ctrl with a 5-entry FIFO and almost-full threshold 3.
module tb_bsg_fifo_ptr_ctrl;
    import bsg_fifo_pkg::*;

    localparam int unsigned Els = 5;
    localparam int unsigned Thr = 3;
    localparam int unsigned PW  = ptr_width(Els);
    localparam int unsigned CW  = count_width(Els);

    logic clk;
    logic reset_i;
    int   tests;
    int   fails;

    bsg_fifo_ptr_ctrl_if #(.ptr_width_p(PW), .count_width_p(CW)) fifo_if ();

    bsg_fifo_ptr_ctrl #(.els_p(Els), .almost_full_thresh_p(Thr)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .fifo_io (fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset_i        = 1'b1;
        fifo_if.v_i    = 1'b0;
        fifo_if.yumi_i = 1'b0;
        #2;
        chk("rst_empty", 32'(fifo_if.empty_o), 1);
        chk("rst_full", 32'(fifo_if.full_o), 0);
        chk("rst_ready", 32'(fifo_if.ready_o), 1);
        chk("rst_v_o", 32'(fifo_if.v_o), 0);
        chk("rst_af", 32'(fifo_if.almost_full_o), 0);
        chk("rst_count", 32'(fifo_if.count_o), 0);
        chk("rst_waddr", 32'(fifo_if.w_addr_o), 0);
        chk("rst_raddr", 32'(fifo_if.r_addr_o), 0);
        chk("rst_wen0", 32'(fifo_if.w_en_o), 0);
        fifo_if.v_i = 1'b1;
        #1;
        chk("rst_wen1", 32'(fifo_if.w_en_o), 1);
        fifo_if.v_i = 1'b0;
        cycle();
        reset_i = 1'b0;
        cycle();

        // Enqueue three, then reset between edges.
        fifo_if.v_i = 1'b1;
        cycle();
        chk("ms_v_o_after1", 32'(fifo_if.v_o), 1);
        cycle();
        cycle();
        chk("ms_count3", 32'(fifo_if.count_o), 3);
        chk("ms_af3", 32'(fifo_if.almost_full_o), 1);
        fifo_if.v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        chk("ms_count_async", 32'(fifo_if.count_o), 0);
        chk("ms_empty_async", 32'(fifo_if.empty_o), 1);
        chk("ms_raddr_async", 32'(fifo_if.r_addr_o), 0);
        chk("ms_waddr_async", 32'(fifo_if.w_addr_o), 0);
        #1;
        reset_i = 1'b0;
        cycle();

        // Fill to full, watching almost-full rise at 3.
        fifo_if.v_i = 1'b1;
        cycle();
        cycle();
        chk("fill_count2", 32'(fifo_if.count_o), 2);
        chk("fill_af2", 32'(fifo_if.almost_full_o), 0);
        cycle();
        chk("fill_af3", 32'(fifo_if.almost_full_o), 1);
        cycle();
        cycle();
        chk("fill_full", 32'(fifo_if.full_o), 1);
        chk("fill_ready", 32'(fifo_if.ready_o), 0);
        chk("fill_count5", 32'(fifo_if.count_o), 5);
        chk("fill_waddr", 32'(fifo_if.w_addr_o), 0);
        chk("fill_wen_6th", 32'(fifo_if.w_en_o), 0);
        cycle();
        chk("fill_hold_count", 32'(fifo_if.count_o), 5);
        chk("fill_hold_waddr", 32'(fifo_if.w_addr_o), 0);

        // Full with both valid: only the dequeue happens.
        fifo_if.yumi_i = 1'b1;
        #1;
        chk("nb_raddr_n", 32'(fifo_if.r_addr_n_o), 1);
        chk("nb_wen", 32'(fifo_if.w_en_o), 0);
        cycle();
        chk("nb_count4", 32'(fifo_if.count_o), 4);
        chk("nb_ready", 32'(fifo_if.ready_o), 1);
        chk("nb_raddr", 32'(fifo_if.r_addr_o), 1);
        chk("nb_waddr", 32'(fifo_if.w_addr_o), 0);

        // Drain to 2: almost-full falls on the step to 2.
        fifo_if.v_i = 1'b0;
        cycle();
        chk("af_count3", 32'(fifo_if.count_o), 3);
        chk("af_still", 32'(fifo_if.almost_full_o), 1);
        cycle();
        chk("af_count2", 32'(fifo_if.count_o), 2);
        chk("af_fall", 32'(fifo_if.almost_full_o), 0);
        chk("af_raddr3", 32'(fifo_if.r_addr_o), 3);

        // Simultaneous enq+deq for four cycles at count 2.
        fifo_if.v_i = 1'b1;
        #1;
        chk("both_wen", 32'(fifo_if.w_en_o), 1);
        for (int i = 0; i < 4; i++) cycle();
        chk("both_count", 32'(fifo_if.count_o), 2);
        chk("both_waddr", 32'(fifo_if.w_addr_o), 4);
        chk("both_raddr", 32'(fifo_if.r_addr_o), 2);
        chk("both_full", 32'(fifo_if.full_o), 0);
        chk("both_empty", 32'(fifo_if.empty_o), 0);

        fifo_if.v_i = 1'b0;
        cycle();
        cycle();
        fifo_if.yumi_i = 1'b0;
        chk("drain_empty", 32'(fifo_if.empty_o), 1);
        chk("drain_raddr", 32'(fifo_if.r_addr_o), 4);

        // Single enq/deq pairs from a clean reset across the non-power-of-two wrap.
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
        cycle();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("wrap_waddr%0d", i), 32'(fifo_if.w_addr_o), 32'(i % 5));
            fifo_if.v_i = 1'b1;
            cycle();
            fifo_if.v_i = 1'b0;
            chk($sformatf("wrap_cnt1_%0d", i), 32'(fifo_if.count_o), 1);
            chk($sformatf("wrap_ne_%0d", i), 32'(fifo_if.empty_o), 0);
            fifo_if.yumi_i = 1'b1;
            cycle();
            fifo_if.yumi_i = 1'b0;
            chk($sformatf("wrap_cnt0_%0d", i), 32'(fifo_if.count_o), 0);
            chk($sformatf("wrap_e_%0d", i), 32'(fifo_if.empty_o), 1);
            chk($sformatf("wrap_raddr%0d", i), 32'(fifo_if.r_addr_o), 32'((i + 1) % 5));
        end
        chk("wrap_waddr_end", 32'(fifo_if.w_addr_o), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
